e_mdu_issue: RTL and testbench

- Issue and stall controller feeding the E-stage multiply/divide (HI/LO) unit.
- Holds the 4-bit HILO op in the D->E pipeline slot and drives it to the HILO unit.
- Keeps a shadow copy of the unit's multi-cycle busy countdown and raises the D-stage stall when a HILO op would meet a busy unit.
- Also inserts E-stage bubbles on stall/flush and kills ops on exception (req).

---
 rtl/e_mdu_issue.sv | 139 +++++++++++++
 tb/tb_e_mdu_issue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_issue.sv
// E-stage HI/LO issue and stall controller: D->E op register, shadow busy countdown, D-stage stall.
// Optional define MDU_SHADOW_CHECK_EN cross-checks the shadow busy against the HILO unit's busy.
module e_mdu_issue #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] D_HILOtype,
    input  logic       ext_stall,
    input  logic       flush,
    input  logic       req,
    input  logic       HILObusy,
    output logic [3:0] E_HILOtype,
    output logic       stall_D,
    output logic       md_busy,
    output logic [3:0] md_cnt,
    output logic       chk_err
);

    // state | meaning
    // IDLE  | md_cnt == 0, unit free; a mult/div in E loads the countdown
    // COUNT | md_cnt >= 2, unit computing, decrement each edge without req
    // LAST  | md_cnt == 1, next edge without req is the HI/LO commit edge

    localparam logic [3:0] HILO_none  = 4'd0;
    localparam logic [3:0] HILO_mult  = 4'd1;
    localparam logic [3:0] HILO_multu = 4'd2;
    localparam logic [3:0] HILO_div   = 4'd3;
    localparam logic [3:0] HILO_divu  = 4'd4;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt_next;
    logic [3:0] e_next;
    logic       e_start;
    logic       e_is_mul;
    logic       e_is_div;

    assign e_is_mul = (E_HILOtype == HILO_mult) || (E_HILOtype == HILO_multu);
    assign e_is_div = (E_HILOtype == HILO_div)  || (E_HILOtype == HILO_divu);
    assign e_start  = e_is_mul || e_is_div;

    always_comb begin
        if (md_cnt == 4'd0) begin
            state = IDLE;
        end else if (md_cnt == 4'd1) begin
            state = LAST;
        end else begin
            state = COUNT;
        end
    end

    // State register and D->E slot
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt     <= 4'd0;
            E_HILOtype <= HILO_none;
        end else begin
            md_cnt     <= cnt_next;
            E_HILOtype <= e_next;
        end
    end

    // Next state; req freezes the countdown just like it freezes the unit
    always_comb begin
        cnt_next = md_cnt;
        if (!req) begin
            case (state)
                IDLE: begin
                    if (e_is_mul) begin
                        cnt_next = MUL_CNT;
                    end else if (e_is_div) begin
                        cnt_next = DIV_CNT;
                    end
                end
                COUNT,
                LAST: cnt_next = md_cnt - 4'd1;
                default: cnt_next = 4'd0;
            endcase
        end
    end

    // Outputs: any HILO op in D waits until the unit is idle and nothing is starting
    always_comb begin
        md_busy = (state != IDLE);
        stall_D = (D_HILOtype != HILO_none) && (e_start || md_busy);
        e_next  = D_HILOtype;
        if (req || flush || stall_D || ext_stall) begin
            e_next = HILO_none;
        end
    end

`ifdef MDU_SHADOW_CHECK_EN
    logic chk_q;
    logic mismatch;

    assign mismatch = (HILObusy != (e_start || md_busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= 1'b0;
        end else if (mismatch) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;

`ifndef SYNTHESIS
    logic [31:0] cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= 32'd0;
        end else begin
            cyc <= cyc + 32'd1;
            if (mismatch) begin
                $display("e_mdu_issue: shadow busy disagrees with unit at cycle %0d, md_cnt=%0d", cyc, md_cnt);
            end
        end
    end
`endif
`else
    logic unused_hilobusy;

    assign unused_hilobusy = HILObusy;
    assign chk_err         = 1'b0;
`endif

endmodule

// File: tb/tb_e_mdu_issue.sv
// Self-checking bench for e_mdu_issue: table-driven cycle vectors plus hand-written reset/shadow sequences.
module tb_e_mdu_issue;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTLO  = 4'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] D_HILOtype = 4'd0;
    logic       ext_stall = 1'b0;
    logic       flush = 1'b0;
    logic       req = 1'b0;
    logic       HILObusy = 1'b0;
    logic [3:0] E_HILOtype;
    logic       stall_D;
    logic       md_busy;
    logic [3:0] md_cnt;
    logic       chk_err;

    int n_checks = 0;
    int n_fail   = 0;

    e_mdu_issue #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_HILOtype (D_HILOtype),
        .ext_stall  (ext_stall),
        .flush      (flush),
        .req        (req),
        .HILObusy   (HILObusy),
        .E_HILOtype (E_HILOtype),
        .stall_D    (stall_D),
        .md_busy    (md_busy),
        .md_cnt     (md_cnt),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] d;
        logic       xs;
        logic       fl;
        logic       rq;
        logic [3:0] e;
        logic       st;
        logic [3:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string name, input logic [3:0] d, input logic xs, input logic fl,
                                input logic rq, input logic [3:0] e, input logic st, input logic [3:0] cnt);
        vec_t v;
        v.name = name; v.d = d; v.xs = xs; v.fl = fl; v.rq = rq;
        v.e = e; v.st = st; v.cnt = cnt;
        vq.push_back(v);
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    initial begin
        int waited;

        // mult then mfhi (ext_stall and flush overlap a HILO stall in cycles 3 and 4)
        add("mul_c0", MULT, 0, 0, 0, NONE, 0, 0);
        add("mul_c1", MFHI, 0, 0, 0, MULT, 1, 0);
        add("mul_c2", MFHI, 0, 0, 0, NONE, 1, 5);
        add("mul_c3", MFHI, 1, 0, 0, NONE, 1, 4);
        add("mul_c4", MFHI, 0, 1, 0, NONE, 1, 3);
        add("mul_c5", MFHI, 0, 0, 0, NONE, 1, 2);
        add("mul_c6", MFHI, 0, 0, 0, NONE, 1, 1);
        add("mul_c7", MFHI, 0, 0, 0, NONE, 0, 0);
        add("mul_c8", NONE, 0, 0, 0, MFHI, 0, 0);
        add("mul_c9", NONE, 0, 0, 0, NONE, 0, 0);
        // divu back-to-back: second one stalled 11 cycles
        add("div_c0", DIVU, 0, 0, 0, NONE, 0, 0);
        add("div_c1", DIVU, 0, 0, 0, DIVU, 1, 0);
        for (int i = 0; i < 10; i++) add($sformatf("div_c%0d", i + 2), DIVU, 0, 0, 0, NONE, 1, 4'(10 - i));
        add("div_c12", DIVU, 0, 0, 0, NONE, 0, 0);
        add("div_c13", NONE, 0, 0, 0, DIVU, 0, 0);
        add("div_c14", NONE, 0, 0, 0, NONE, 0, 10);
        for (int i = 0; i < 10; i++) add($sformatf("div_drain%0d", i), NONE, 0, 0, 0, NONE, 0, 4'(9 - i));
        // exception kill, then req hold mid-count
        add("exc_c0", MULT, 0, 0, 0, NONE, 0, 0);
        add("exc_c1", NONE, 0, 0, 1, MULT, 0, 0);
        add("exc_c2", MULT, 0, 0, 0, NONE, 0, 0);
        add("exc_c3", NONE, 0, 0, 0, MULT, 0, 0);
        add("exc_c4", NONE, 0, 0, 0, NONE, 0, 5);
        add("exc_c5", NONE, 0, 0, 1, NONE, 0, 4);
        add("exc_c6", NONE, 0, 0, 1, NONE, 0, 4);
        add("exc_c7", NONE, 0, 0, 1, NONE, 0, 4);
        add("exc_c8", NONE, 0, 0, 0, NONE, 0, 4);
        add("exc_c9", NONE, 0, 0, 0, NONE, 0, 3);
        add("exc_c10", NONE, 0, 0, 0, NONE, 0, 2);
        add("exc_c11", NONE, 0, 0, 0, NONE, 0, 1);
        add("exc_c12", NONE, 0, 0, 0, NONE, 0, 0);
        // mtlo/mflo never busy; flushed multu never issues
        add("mt_c0", MTLO, 0, 0, 0, NONE, 0, 0);
        add("mt_c1", MFLO, 0, 0, 0, MTLO, 0, 0);
        add("mt_c2", NONE, 0, 0, 0, MFLO, 0, 0);
        add("fl_c3", MULTU, 0, 1, 0, NONE, 0, 0);
        add("fl_c4", MULT, 1, 0, 0, NONE, 0, 0);
        add("fl_c5", NONE, 0, 0, 0, NONE, 0, 0);

        // reset state
        tick(); tick();
        chk("rst_e", E_HILOtype, 0);
        chk("rst_cnt", md_cnt, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_chk_err", chk_err, 0);
        reset = 1'b0;
        chk("rst_stall", stall_D, 0);
        tick();

        foreach (vq[i]) begin
            D_HILOtype = vq[i].d;
            ext_stall  = vq[i].xs;
            flush      = vq[i].fl;
            req        = vq[i].rq;
            HILObusy   = is_start(vq[i].e) || (vq[i].cnt != 0);
            #1;
            chk({vq[i].name, "_e"}, E_HILOtype, vq[i].e);
            chk({vq[i].name, "_stall"}, stall_D, vq[i].st);
            chk({vq[i].name, "_cnt"}, md_cnt, vq[i].cnt);
            chk({vq[i].name, "_busy"}, md_busy, (vq[i].cnt != 0));
            tick();
        end
        D_HILOtype = NONE; ext_stall = 0; flush = 0; req = 0;
        chk("after_table_chk_err", chk_err, 0);

        // reset mid-countdown with a div still presented in D
        D_HILOtype = DIV;
        tick();
        D_HILOtype = DIV;
        waited = 0;
        while (md_cnt != 4'd6 && waited < 30) begin
            tick();
            waited++;
        end
        chk("rstmid_reach6", md_cnt, 6);
        reset = 1'b1;
        tick();
        chk("rstmid_cnt", md_cnt, 0);
        chk("rstmid_e", E_HILOtype, 0);
        chk("rstmid_stall", stall_D, 0);
        reset = 1'b0;
        D_HILOtype = NONE;
        tick(); tick();

`ifdef MDU_SHADOW_CHECK_EN
        // unit busy drops one cycle early during a mult countdown
        D_HILOtype = MULT;
        tick();
        D_HILOtype = NONE;
        for (int c = 0; c < 6; c++) begin
            HILObusy = (c < 5);
            #1;
            tick();
        end
        HILObusy = 1'b0;
        chk("shadow_err_set", chk_err, 1);
        tick(); tick();
        chk("shadow_err_sticky", chk_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("shadow_err_cleared", chk_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
